surf_debug_mux_scheduler: RTL and testbench
===========================================

// Module: surf_debug_mux_scheduler
// PURPOSE
//  Time-shares the 4:1 registered SURF debug multiplexer (35-bit, 1-cycle latency) among
//  four debug requesters. Drives the mux 2-bit select and rotates it round-robin, with a
//  programmable dwell per grant. A manual override pins the select from the control path.
//  Flags when the mux output carries data for the current select.
// PARAMETERS
//  DWELL_W  8  width of dwell_i and of the internal dwell counter
// PORTS
//  clk_i      in   1        system clock; all logic on posedge
//  rst_i      in   1        synchronous, active-high reset
//  req_i      in   4        per-requester debug request; bit n = mux input n
//  ovr_en_i   in   1        manual override enable
//  ovr_sel_i  in   2        override select value
//  dwell_i    in   DWELL_W  grant dwell in cycles; 0 treated as 1
//  freeze_i   in   1        hold current grant (see CONFIGURATION)
//  sel_o      out  2        to mux sel_i
//  gnt_o      out  4        one-hot grant; all-zero in IDLE/OVR
//  valid_o    out  1        mux out reflects sel_o this cycle
//  switch_o   out  1        1-cycle pulse, cycle after an edge that changed sel_o
// BEHAVIOUR
//  Reset: state=IDLE, sel_o=0, gnt_o=0, valid_o=0, switch_o=0, cnt=0, last=3.
//  All outputs registered. States IDLE, GRANT, OVR. Priority per edge: rst > ovr > arbitration.
//  Round-robin pick: first set req_i bit scanning last+1, last+2, ... (mod 4, wraps 3->0).
//  IDLE: ovr_en_i -> OVR. Else any req_i -> GRANT, sel_o=pick, gnt_o=1<<pick, last=pick,
//   cnt=0. No req: stay, sel_o holds old value, gnt_o=0.
//  GRANT: cnt+1 per cycle, saturating at all-ones.
//   ovr_en_i -> OVR immediately, gnt_o=0.
//   req_i[sel_o] low -> re-arbitrate same edge (pick excludes none; current bit is 0):
//    other req -> new grant, cnt=0; none -> IDLE, gnt_o=0, sel_o holds.
//   cnt >= max(dwell_i,1)-1 and another req pending -> rotate to pick, cnt=0.
//   Dwell expiry with only own req pending -> keep grant, cnt=0.
//   dwell_i changed mid-grant: new value used on next compare.
//  OVR: sel_o=ovr_sel_i every edge, gnt_o=0, cnt=0. ovr_en_i low -> IDLE next edge;
//   arbitration resumes the edge after (no grant on exit edge).
//  switch_o=1 for exactly one cycle after any edge where sel_o changed value; re-grant of
//   same index, or OVR with unchanged ovr_sel_i, gives no pulse.
//  valid_o: 0 in cycle after sel_o change (mux still shows old input), 1 afterward while
//   state is GRANT or OVR with sel_o stable; 0 in IDLE. Reset mid-operation: all outputs to
//   reset values next edge, no pulse on switch_o.
// CONFIGURATION
//  SURF_DEBUG_SCHED_FREEZE_EN defined: in GRANT, freeze_i=1 suppresses dwell rotation and
//   holds cnt; request drop and override still act. freeze_i ignored in IDLE/OVR.
//  Undefined: freeze_i port present but ignored; no freeze logic synthesised.
// TESTING
//  Reset then req_i=4'b0000 10 cyc -> IDLE, sel_o=0, gnt_o=0, valid_o=0, switch_o=0.
//  req_i=4'b1111, dwell_i=4 -> grants 0,1,2,3,0 each held 4 cyc; switch_o pulse each
//   change; valid_o low 1 cyc after each change.
//  req_i=4'b0100 steady, dwell_i=2 -> gnt_o=4'b0100 held indefinitely, switch_o single pulse.
//  In GRANT idx 1, drop req_i[1] with req_i[3]=1 -> next edge sel_o=3, gnt_o=4'b1000, cnt=0.
//  ovr_en_i=1, ovr_sel_i=2 during GRANT -> sel_o=2, gnt_o=0, valid_o=1 after 1 cyc;
//   release -> IDLE 1 cyc then round-robin from last+1.
//  FREEZE_EN build: req_i=4'b0011, dwell_i=3, freeze_i=1 at cnt=1 -> grant 0 held while
//   frozen; freeze_i=0 -> rotate to 1 after 1 more cyc. Non-FREEZE build: rotates at cnt=2.

Source files
------------

// File: rtl/surf_debug_mux_scheduler.sv
// ============================================================================
// Module   : surf_debug_mux_scheduler
// Brief    : Round-robin select scheduler for the 4:1 registered SURF debug mux,
//            with per-grant dwell, manual override and mux-output valid flag.
//            Optional dwell freeze when SURF_DEBUG_SCHED_FREEZE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module surf_debug_mux_scheduler #(
    parameter int DWELL_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [3:0]         req_i,
    input  logic               ovr_en_i,
    input  logic [1:0]         ovr_sel_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic               freeze_i,
    output logic [1:0]         sel_o,
    output logic [3:0]         gnt_o,
    output logic               valid_o,
    output logic               switch_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_OVR   = 2'd2
    } state_t;

    state_t             r_state;
    logic [1:0]         r_sel;
    logic [1:0]         r_last;
    logic [3:0]         r_gnt;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_valid;
    logic               r_switch;

    logic               w_freeze;
    logic [DWELL_W-1:0] w_dwell_m1;
    logic               w_own_req;
    logic               w_other_req;
    logic               w_expired;
    logic               w_take;
    logic [1:0]         w_pick;

`ifdef SURF_DEBUG_SCHED_FREEZE_EN
    assign w_freeze = freeze_i;
`else
    logic w_unused_freeze;
    assign w_unused_freeze = freeze_i;
    assign w_freeze        = 1'b0;
`endif

    // First requester after the last grant, wrapping 3->0; the last index is scanned last.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = last;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        w_dwell_m1  = (dwell_i == '0) ? '0 : dwell_i - DWELL_W'(1);
        w_own_req   = req_i[r_sel];
        w_other_req = |(req_i & ~(4'b0001 << r_sel));
        w_expired   = (r_cnt >= w_dwell_m1);
        w_pick      = rr_pick(req_i, r_last);
        w_take      = 1'b0;
        if (r_state == ST_IDLE) begin
            w_take = |req_i;
        end else if (r_state == ST_GRANT) begin
            w_take = (!w_own_req && (|req_i)) ||
                     (w_own_req && !w_freeze && w_expired && w_other_req);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_sel    <= 2'd0;
            r_last   <= 2'd3;
            r_gnt    <= 4'b0000;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_switch <= 1'b0;
        end else if (ovr_en_i) begin
            r_state  <= ST_OVR;
            r_sel    <= ovr_sel_i;
            r_gnt    <= 4'b0000;
            r_cnt    <= '0;
            r_switch <= (ovr_sel_i != r_sel);
            r_valid  <= (ovr_sel_i == r_sel);
        end else if (w_take) begin
            r_state  <= ST_GRANT;
            r_sel    <= w_pick;
            r_last   <= w_pick;
            r_gnt    <= 4'b0001 << w_pick;
            r_cnt    <= '0;
            r_switch <= (w_pick != r_sel);
            r_valid  <= (w_pick == r_sel);
        end else begin
            r_switch <= 1'b0;
            case (r_state)
                ST_GRANT: begin
                    if (!w_own_req) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= 4'b0000;
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                    end else begin
                        r_valid <= 1'b1;
                        if (!w_freeze) begin
                            // Expiry with nobody else waiting restarts the dwell window.
                            if (w_expired)
                                r_cnt <= '0;
                            else if (r_cnt != '1)
                                r_cnt <= r_cnt + DWELL_W'(1);
                        end
                    end
                end
                ST_OVR: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 4'b0000;
                    r_cnt   <= '0;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 4'b0000;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign sel_o    = r_sel;
    assign gnt_o    = r_gnt;
    assign valid_o  = r_valid;
    assign switch_o = r_switch;

endmodule

`default_nettype wire

// File: tb/tb_surf_debug_mux_scheduler.sv
// ============================================================================
// Module   : tb_surf_debug_mux_scheduler
// Brief    : Self-checking bench: vector table, corner sequences and random
//            stimulus against a cycle-level reference of the scheduling rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_surf_debug_mux_scheduler;

`ifdef SURF_DEBUG_SCHED_FREEZE_EN
    localparam bit c_FREEZE_BUILD = 1'b1;
`else
    localparam bit c_FREEZE_BUILD = 1'b0;
`endif

    localparam int c_MODE_IDLE  = 0;
    localparam int c_MODE_GRANT = 1;
    localparam int c_MODE_OVR   = 2;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [3:0] req_i = 4'b0000;
    logic       ovr_en_i = 1'b0;
    logic [1:0] ovr_sel_i = 2'd0;
    logic [7:0] dwell_i = 8'd2;
    logic       freeze_i = 1'b0;
    logic [1:0] sel_o;
    logic [3:0] gnt_o;
    logic       valid_o;
    logic       switch_o;

    int total = 0;
    int bad   = 0;

    // Reference state
    int m_mode, m_sel, m_last, m_cnt, m_gnt, m_valid, m_sw;

    surf_debug_mux_scheduler #(.DWELL_W(8)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .ovr_en_i  (ovr_en_i),
        .ovr_sel_i (ovr_sel_i),
        .dwell_i   (dwell_i),
        .freeze_i  (freeze_i),
        .sel_o     (sel_o),
        .gnt_o     (gnt_o),
        .valid_o   (valid_o),
        .switch_o  (switch_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    function automatic int next_owner(input int req, input int last);
        for (int k = 1; k <= 4; k++)
            if (((req >> ((last + k) % 4)) & 1) != 0) return (last + k) % 4;
        return -1;
    endfunction

    task automatic award(input int who);
        m_mode = c_MODE_GRANT;
        m_sel  = who;
        m_last = who;
        m_cnt  = 0;
    endtask

    task automatic model_step();
        int prev_sel, req, dwell_len;
        prev_sel  = m_sel;
        req       = int'(req_i);
        dwell_len = (dwell_i == 0) ? 1 : int'(dwell_i);
        if (rst_i) begin
            m_mode = c_MODE_IDLE; m_sel = 0; m_last = 3; m_cnt = 0;
            m_gnt = 0; m_valid = 0; m_sw = 0;
            return;
        end
        if (ovr_en_i) begin
            m_mode = c_MODE_OVR; m_sel = int'(ovr_sel_i); m_cnt = 0;
        end else if (m_mode == c_MODE_OVR) begin
            m_mode = c_MODE_IDLE; m_cnt = 0;
        end else if (m_mode == c_MODE_IDLE) begin
            if (req != 0) award(next_owner(req, m_last));
        end else if (((req >> m_sel) & 1) == 0) begin
            if (req != 0) award(next_owner(req, m_last));
            else begin m_mode = c_MODE_IDLE; m_cnt = 0; end
        end else if (!(c_FREEZE_BUILD && freeze_i)) begin
            // The grant has run its full dwell once cnt+1 reaches the dwell length.
            if (m_cnt + 1 >= dwell_len) begin
                if ((req & ~(1 << m_sel)) != 0) award(next_owner(req, m_last));
                else m_cnt = 0;
            end else begin
                m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
            end
        end
        m_gnt   = (m_mode == c_MODE_GRANT) ? (1 << m_sel) : 0;
        m_sw    = (m_sel != prev_sel) ? 1 : 0;
        m_valid = (m_mode != c_MODE_IDLE && m_sw == 0) ? 1 : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_sel",    int'(sel_o),    m_sel);
        check("model_gnt",    int'(gnt_o),    m_gnt);
        check("model_valid",  int'(valid_o),  m_valid);
        check("model_switch", int'(switch_o), m_sw);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    typedef struct {
        logic [3:0] req;
        logic       ovr_en;
        logic [1:0] ovr_sel;
        logic [7:0] dwell;
        logic [1:0] e_sel;
        logic [3:0] e_gnt;
        logic       e_valid;
        logic       e_sw;
    } vec_t;

    vec_t tbl[17];
    int   sw_count;

    initial begin
        // Hand-derived sequence starting just after reset (last=3, sel=0).
        tbl[0]  = '{4'b0000, 1'b0, 2'd0, 8'd2, 2'd0, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{4'b1111, 1'b0, 2'd0, 8'd2, 2'd0, 4'b0001, 1'b1, 1'b0};
        tbl[2]  = '{4'b1111, 1'b0, 2'd0, 8'd2, 2'd0, 4'b0001, 1'b1, 1'b0};
        tbl[3]  = '{4'b1111, 1'b0, 2'd0, 8'd2, 2'd1, 4'b0010, 1'b0, 1'b1};
        tbl[4]  = '{4'b1111, 1'b0, 2'd0, 8'd2, 2'd1, 4'b0010, 1'b1, 1'b0};
        tbl[5]  = '{4'b1111, 1'b0, 2'd0, 8'd2, 2'd2, 4'b0100, 1'b0, 1'b1};
        tbl[6]  = '{4'b0100, 1'b0, 2'd0, 8'd2, 2'd2, 4'b0100, 1'b1, 1'b0};
        tbl[7]  = '{4'b0100, 1'b0, 2'd0, 8'd2, 2'd2, 4'b0100, 1'b1, 1'b0};
        tbl[8]  = '{4'b1000, 1'b0, 2'd0, 8'd2, 2'd3, 4'b1000, 1'b0, 1'b1};
        tbl[9]  = '{4'b1000, 1'b1, 2'd1, 8'd2, 2'd1, 4'b0000, 1'b0, 1'b1};
        tbl[10] = '{4'b1000, 1'b1, 2'd1, 8'd2, 2'd1, 4'b0000, 1'b1, 1'b0};
        tbl[11] = '{4'b1000, 1'b0, 2'd1, 8'd2, 2'd1, 4'b0000, 1'b0, 1'b0};
        tbl[12] = '{4'b1000, 1'b0, 2'd0, 8'd2, 2'd3, 4'b1000, 1'b0, 1'b1};
        tbl[13] = '{4'b0000, 1'b0, 2'd0, 8'd2, 2'd3, 4'b0000, 1'b0, 1'b0};
        tbl[14] = '{4'b1001, 1'b0, 2'd0, 8'd0, 2'd0, 4'b0001, 1'b0, 1'b1};
        tbl[15] = '{4'b1001, 1'b0, 2'd0, 8'd0, 2'd3, 4'b1000, 1'b0, 1'b1};
        tbl[16] = '{4'b1001, 1'b0, 2'd0, 8'd0, 2'd0, 4'b0001, 1'b0, 1'b1};

        // Reset state and idle with no requests
        do_reset();
        check("rst_sel",   int'(sel_o),    0);
        check("rst_gnt",   int'(gnt_o),    0);
        check("rst_valid", int'(valid_o),  0);
        check("rst_sw",    int'(switch_o), 0);
        for (int i = 0; i < 10; i++) tick();
        check("idle_gnt", int'(gnt_o), 0);
        check("idle_sel", int'(sel_o), 0);

        // Vector table
        do_reset();
        for (int i = 0; i < 17; i++) begin
            req_i = tbl[i].req; ovr_en_i = tbl[i].ovr_en;
            ovr_sel_i = tbl[i].ovr_sel; dwell_i = tbl[i].dwell;
            tick();
            check($sformatf("vec%0d_sel", i),   int'(sel_o),    int'(tbl[i].e_sel));
            check($sformatf("vec%0d_gnt", i),   int'(gnt_o),    int'(tbl[i].e_gnt));
            check($sformatf("vec%0d_valid", i), int'(valid_o),  int'(tbl[i].e_valid));
            check($sformatf("vec%0d_sw", i),    int'(switch_o), int'(tbl[i].e_sw));
        end
        ovr_en_i = 1'b0;

        // Steady single requester: one switch pulse, grant held
        do_reset();
        req_i = 4'b0100; dwell_i = 8'd2; sw_count = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            sw_count += int'(switch_o);
        end
        check("steady_pulses", sw_count, 1);
        check("steady_gnt", int'(gnt_o), 4);

        // Full rotation with dwell 4: pulses spaced exactly 4 cycles apart
        do_reset();
        req_i = 4'b1111; dwell_i = 8'd4;
        tick();
        check("rot_first_gnt", int'(gnt_o), 1);
        for (int g = 1; g <= 4; g++) begin
            for (int c = 0; c < 3; c++) tick();
            check("rot_hold_gnt", int'(gnt_o), 1 << ((g - 1) % 4));
            tick();
            check("rot_next_gnt", int'(gnt_o), 1 << (g % 4));
            check("rot_pulse", int'(switch_o), 1);
        end

        // Request drop hands over to the next requester on the same edge
        do_reset();
        req_i = 4'b0010; dwell_i = 8'd8;
        tick(); tick();
        check("drop_pre_sel", int'(sel_o), 1);
        req_i = 4'b1000;
        tick();
        check("drop_sel", int'(sel_o), 3);
        check("drop_gnt", int'(gnt_o), 8);

        // Override during grant, then release and resume from last+1
        req_i = 4'b1111; ovr_en_i = 1'b1; ovr_sel_i = 2'd2;
        tick();
        check("ovr_sel", int'(sel_o), 2);
        check("ovr_gnt", int'(gnt_o), 0);
        check("ovr_valid0", int'(valid_o), 0);
        tick();
        check("ovr_valid1", int'(valid_o), 1);
        ovr_en_i = 1'b0;
        tick();
        check("ovr_exit_gnt", int'(gnt_o), 0);
        tick();
        check("ovr_resume_gnt", int'(gnt_o), 1);

        // Freeze at cnt=1 with dwell 3
        do_reset();
        req_i = 4'b0011; dwell_i = 8'd3; freeze_i = 1'b0;
        tick(); tick();
        freeze_i = 1'b1;
        tick(); tick();
        check("frz_sel", int'(sel_o), c_FREEZE_BUILD ? 0 : 1);
        tick(); tick(); tick();
        freeze_i = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // Randomised traffic against the reference
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_i    = ($urandom_range(0, 299) == 0);
            req_i    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req_i = 4'b0000;
            if ($urandom_range(0, 15) == 0) ovr_en_i = ~ovr_en_i;
            ovr_sel_i = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : ovr_sel_i;
            dwell_i  = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 5)) : dwell_i;
            freeze_i = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
